serial_frame_rx: RTL and testbench

Framed serial receiver: the far end of the serial link whose transmit side is the team's `shift_register` parallel-to-serial path. It samples a start/data/parity/stop framed bitstream (MSB first), checks framing and parity, and presents each good word on a parallel valid/ready output port. It sits between the serial pin domain (already synchronous to `i_clk`) and the consuming datapath.

---
 rtl/serial_frame_rx.sv | 167 ++++++++++++++++
 tb/tb_serial_frame_rx.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_rx.sv
// -----------------------------------------------------------------------------
// serial_frame_rx
//
// Framed serial receiver. Samples a start/data/parity/stop framed bitstream
// (MSB first) on clock edges qualified by i_bit_en, checks even parity and the
// stop bit, and presents each good word on a valid/ready output port.
//
// Parameters
//   DWIDTH     data bits per frame (4..16)
//   PARITY_EN  1: an even-parity bit follows the data; 0: no parity bit
//
// Ports
//   i_clk      system clock, rising edge
//   i_rstn     asynchronous active-low reset
//   i_bit_en   bit strobe; i_ser_in is sampled only when this is 1
//   i_ser_in   serial line, idles high
//   o_par_out  received word, held while o_valid is high
//   o_valid    word available
//   i_ready    consumer accepts the word
//   o_par_err  one-cycle pulse: frame failed the parity check
//   o_frm_err  one-cycle pulse: stop bit sampled as 0
//   o_overrun  one-cycle pulse: good frame dropped because output was full
//   o_busy     high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module serial_frame_rx #(
  parameter int DWIDTH    = 8,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_bit_en,
  input  logic              i_ser_in,
  output logic [DWIDTH-1:0] o_par_out,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_par_err,
  output logic              o_frm_err,
  output logic              o_overrun,
  output logic              o_busy
);

  localparam int CW = $clog2(DWIDTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  state_t            state_reg,   state_next;
  logic [CW-1:0]     cnt_reg,     cnt_next;
  logic [DWIDTH-1:0] shift_reg,   shift_next;
  logic              par_ok_reg,  par_ok_next;
  logic [DWIDTH-1:0] out_reg,     out_next;
  logic              valid_reg,   valid_next;
  logic              par_err_reg, par_err_next;
  logic              frm_err_reg, frm_err_next;
  logic              ovr_reg,     ovr_next;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= '0;
      shift_reg   <= '0;
      par_ok_reg  <= 1'b1;
      out_reg     <= '0;
      valid_reg   <= 1'b0;
      par_err_reg <= 1'b0;
      frm_err_reg <= 1'b0;
      ovr_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      shift_reg   <= shift_next;
      par_ok_reg  <= par_ok_next;
      out_reg     <= out_next;
      valid_reg   <= valid_next;
      par_err_reg <= par_err_next;
      frm_err_reg <= frm_err_next;
      ovr_reg     <= ovr_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    shift_next   = shift_reg;
    par_ok_next  = par_ok_reg;
    out_next     = out_reg;
    valid_next   = valid_reg;
    // Pulses default low so they last exactly one clock whatever the strobe rate.
    par_err_next = 1'b0;
    frm_err_next = 1'b0;
    ovr_next     = 1'b0;

    // Handshake runs on every edge, strobed or not. A load in STOP below
    // overrides this, keeping o_valid high with the new word.
    if (valid_reg && i_ready) begin
      valid_next = 1'b0;
    end

    if (i_bit_en) begin
      unique case (state_reg)
        S_IDLE: begin
          if (!i_ser_in) begin
            state_next  = S_DATA;
            cnt_next    = '0;
            shift_next  = '0;
            // Without a parity bit the check trivially passes.
            par_ok_next = 1'b1;
          end
        end

        S_DATA: begin
          shift_next = {shift_reg[DWIDTH-2:0], i_ser_in};
          cnt_next   = cnt_reg + 1'b1;
          if (cnt_reg == CW'(DWIDTH - 1)) begin
            state_next = PARITY_EN ? S_PARITY : S_STOP;
          end
        end

        S_PARITY: begin
          // Even parity: XOR over data and parity bit must be 0.
          par_ok_next = ~((^shift_reg) ^ i_ser_in);
          state_next  = S_STOP;
        end

        S_STOP: begin
          if (!i_ser_in) begin
            // Framing error wins over parity; wait for the line to go high
            // so a held-low break is not seen as repeated start bits.
            frm_err_next = 1'b1;
            state_next   = S_WAIT_IDLE;
          end else begin
            state_next = S_IDLE;
            if (!par_ok_reg) begin
              par_err_next = 1'b1;
            end else if (!valid_reg || i_ready) begin
              out_next   = shift_reg;
              valid_next = 1'b1;
            end else begin
              ovr_next = 1'b1;
            end
          end
        end

        S_WAIT_IDLE: begin
          if (i_ser_in) begin
            state_next = S_IDLE;
          end
        end

        default: state_next = S_IDLE;
      endcase
    end
  end

  assign o_par_out = out_reg;
  assign o_valid   = valid_reg;
  assign o_par_err = par_err_reg;
  assign o_frm_err = frm_err_reg;
  assign o_overrun = ovr_reg;
  assign o_busy    = (state_reg != S_IDLE);

endmodule

// File: tb/tb_serial_frame_rx.sv
// -----------------------------------------------------------------------------
// tb_serial_frame_rx
//
// Self-checking bench for serial_frame_rx (DWIDTH=8, PARITY_EN=1). Directed
// frames exercise good data, parity/framing errors, break, overrun and reset
// mid-frame; randomized frames are checked against a frame-level model that
// tracks only the held output word and the expected per-frame outcome.
// -----------------------------------------------------------------------------
module tb_serial_frame_rx;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          bit_en;
  logic          ser_in;
  logic          ready;
  logic [DW-1:0] par_out;
  logic          valid;
  logic          par_err;
  logic          frm_err;
  logic          overrun;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int n_par  = 0;
  int n_frm  = 0;
  int n_ovr  = 0;

  serial_frame_rx #(.DWIDTH(DW), .PARITY_EN(1'b1)) dut (
    .i_clk    (clk),
    .i_rstn   (rst_n),
    .i_bit_en (bit_en),
    .i_ser_in (ser_in),
    .o_par_out(par_out),
    .o_valid  (valid),
    .i_ready  (ready),
    .o_par_err(par_err),
    .o_frm_err(frm_err),
    .o_overrun(overrun),
    .o_busy   (busy)
  );

  always #5 clk = ~clk;

  // Count pulse-high cycles away from the active edge.
  always @(negedge clk) begin
    if (par_err) n_par++;
    if (frm_err) n_frm++;
    if (overrun) n_ovr++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Idle (strobe low) for per-1 cycles, then one strobed sample of b.
  // Returns just after the sampling edge.
  task automatic send_bit(input logic b, input int per);
    bit_en = 1'b0;
    for (int i = 1; i < per; i++) tick();
    ser_in = b;
    bit_en = 1'b1;
    tick();
    bit_en = 1'b0;
    ser_in = 1'b1;
  endtask

  task automatic send_head(input logic [DW-1:0] d, input logic pb, input int per);
    send_bit(1'b0, per);
    for (int i = DW - 1; i >= 0; i--) send_bit(d[i], per);
    send_bit(pb, per);
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic pb, input logic sb, input int per);
    send_head(d, pb, per);
    send_bit(sb, per);
  endtask

  task automatic drain();
    ready = 1'b1;
    tick();
    ready = 1'b0;
  endtask

  logic [DW-1:0] exp_word;
  logic          exp_valid;
  int            p0, f0, o0;

  initial begin
    rst_n  = 1'b0;
    bit_en = 1'b0;
    ser_in = 1'b1;
    ready  = 1'b0;
    tick();
    tick();
    check("rst_par_out", par_out, 0);
    check("rst_valid",   valid,   0);
    check("rst_par_err", par_err, 0);
    check("rst_frm_err", frm_err, 0);
    check("rst_overrun", overrun, 0);
    check("rst_busy",    busy,    0);
    rst_n = 1'b1;
    tick();

    // Good frame 0xA5, parity 0.
    send_head(8'hA5, 1'b0, 1);
    check("a5_busy_mid", busy, 1);
    send_bit(1'b1, 1);
    $display("frame good data=a5 valid=%0d out=%02h", valid, par_out);
    check("a5_valid", valid, 1);
    check("a5_data",  par_out, 8'hA5);
    check("a5_busy",  busy, 0);
    drain();
    check("a5_consumed", valid, 0);

    // Parity error 0x3C with parity 1.
    p0 = n_par;
    send_frame(8'h3C, 1'b1, 1'b1, 1);
    $display("frame parerr data=3c par_err=%0d", par_err);
    check("pe_pulse", par_err, 1);
    check("pe_valid", valid, 0);
    tick();
    check("pe_pulse_end", par_err, 0);
    check("pe_count", n_par - p0, 1);

    // Framing error, then break of 5 low strobes, then high.
    p0 = n_par;
    f0 = n_frm;
    send_frame(8'h81, 1'b0, 1'b0, 1);
    $display("frame frmerr data=81 frm_err=%0d", frm_err);
    check("fe_pulse", frm_err, 1);
    for (int i = 0; i < 5; i++) send_bit(1'b0, 1);
    check("brk_busy", busy, 1);
    send_bit(1'b1, 1);
    tick();
    check("fe_count",  n_frm - f0, 1);
    check("fe_no_par", n_par - p0, 0);
    check("brk_valid", valid, 0);
    check("brk_idle",  busy, 0);
    send_frame(8'h42, 1'b0, 1'b1, 1);
    $display("frame good data=42 valid=%0d out=%02h", valid, par_out);
    check("x42_valid", valid, 1);
    check("x42_data",  par_out, 8'h42);
    drain();

    // Overrun: ready low, two back-to-back frames.
    send_frame(8'h11, 1'b0, 1'b1, 1);
    check("ov1_valid", valid, 1);
    send_frame(8'h22, 1'b0, 1'b1, 1);
    $display("frame overrun data=22 overrun=%0d out=%02h", overrun, par_out);
    check("ov_pulse", overrun, 1);
    check("ov_keep",  par_out, 8'h11);
    check("ov_valid", valid, 1);
    tick();
    check("ov_pulse_end", overrun, 0);
    check("ov_hold", par_out, 8'h11);
    drain();
    check("ov_drained", valid, 0);

    // Same, but ready asserted on the second stop-bit edge.
    o0 = n_ovr;
    send_frame(8'h11, 1'b0, 1'b1, 1);
    send_head(8'h22, 1'b0, 1);
    ready = 1'b1;
    send_bit(1'b1, 1);
    ready = 1'b0;
    $display("frame replace data=22 valid=%0d out=%02h", valid, par_out);
    check("rp_valid", valid, 1);
    check("rp_data",  par_out, 8'h22);
    tick();
    check("rp_no_ovr", n_ovr - o0, 0);
    drain();

    // Strobed rate: 32 random clean words, strobe 1 in 4, ready high.
    p0 = n_par; f0 = n_frm; o0 = n_ovr;
    ready = 1'b1;
    for (int k = 0; k < 32; k++) begin
      logic [DW-1:0] w;
      w = DW'($urandom);
      send_frame(w, ^w, 1'b1, 4);
      $display("frame strobed %0d data=%02h valid=%0d out=%02h", k, w, valid, par_out);
      check("str_valid", valid, 1);
      check("str_data",  par_out, w);
    end
    send_bit(1'b1, 4);
    ready = 1'b0;
    check("str_par_errs", n_par - p0, 0);
    check("str_frm_errs", n_frm - f0, 0);
    check("str_ovr",      n_ovr - o0, 0);
    check("str_drained",  valid, 0);

    // Random frames with injected faults and random ready, frame-level model.
    exp_valid = 1'b0;
    exp_word  = '0;
    for (int k = 0; k < 24; k++) begin
      logic [DW-1:0] d;
      int kind, per;
      logic r, e_par, e_frm, e_ovr;
      d    = DW'($urandom);
      kind = $urandom_range(0, 3);   // 0 parity fault, 1 stop fault, else good
      per  = $urandom_range(1, 3);
      r    = 1'($urandom_range(0, 1));
      ready = r;
      if (r) exp_valid = 1'b0;
      p0 = n_par; f0 = n_frm; o0 = n_ovr;
      send_frame(d, (^d) ^ (kind == 0), kind != 1, per);
      e_par = 1'b0; e_frm = 1'b0; e_ovr = 1'b0;
      if (kind == 1)      e_frm = 1'b1;
      else if (kind == 0) e_par = 1'b1;
      else if (exp_valid) e_ovr = 1'b1;
      else begin
        exp_word  = d;
        exp_valid = 1'b1;
      end
      $display("frame random %0d data=%02h kind=%0d ready=%0d valid=%0d out=%02h",
               k, d, kind, r, valid, par_out);
      check("rnd_valid", valid, exp_valid);
      if (exp_valid) check("rnd_data", par_out, exp_word);
      send_bit(1'b1, per);
      check("rnd_par", n_par - p0, e_par);
      check("rnd_frm", n_frm - f0, e_frm);
      check("rnd_ovr", n_ovr - o0, e_ovr);
      if (r) exp_valid = 1'b0;
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;

    // Reset mid-frame after the 4th data bit of 0xF0.
    send_bit(1'b0, 1);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1);
    check("mr_busy_before", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    $display("frame reset_mid busy=%0d valid=%0d", busy, valid);
    check("mr_busy",    busy,    0);
    check("mr_valid",   valid,   0);
    check("mr_par_out", par_out, 0);
    check("mr_pulses",  {29'd0, par_err, frm_err, overrun}, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    send_frame(8'h0F, 1'b0, 1'b1, 1);
    $display("frame good data=0f valid=%0d out=%02h", valid, par_out);
    check("x0f_valid", valid, 1);
    check("x0f_data",  par_out, 8'h0F);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
